// File: rtl/branch_pred_pkg.sv
// Shared branch-prediction types and PC slicing helpers.
// Used by the BTB and the local-history direction predictor.
package branch_pred_pkg;

    localparam int BTB_DEPTH   = 6;
    localparam int TAG_W       = 30 - BTB_DEPTH;
    localparam int BTB_ENTRIES = 1 << BTB_DEPTH;
    localparam int LHT_IDX_W   = 10;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [29:0]      target;
    } btb_entry_t;

    function automatic logic [BTB_DEPTH-1:0] btb_idx(
        input logic [31:0] pc
    );
        return pc[BTB_DEPTH+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] btb_tag(
        input logic [31:0] pc
    );
        return pc[31:BTB_DEPTH+2];
    endfunction

    function automatic logic [LHT_IDX_W-1:0] lht_idx(
        input logic [31:0] pc
    );
        return pc[LHT_IDX_W+1:2];
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB entry store: one async read port,
// one write port and a bulk invalidate of all valid bits.
module btb_array
    import branch_pred_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic [BTB_DEPTH-1:0] raddr_i,
    output btb_entry_t           rentry_o,
    input  logic                 we_i,
    input  logic [BTB_DEPTH-1:0] waddr_i,
    input  logic [TAG_W-1:0]     wtag_i,
    input  logic [29:0]          wtarget_i
);

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [29:0]            tgt_q [BTB_ENTRIES];

    // Valid-bit next state: clear wins over a write.
    always_comb begin
        valid_d = valid_q;
        if (clr_i) begin
            valid_d = '0;
        end else if (we_i) begin
            valid_d[waddr_i] = 1'b1;
        end
    end

    // Valid bits are the only reset state in the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/target storage; contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (we_i && !clr_i) begin
            tag_q[waddr_i] <= wtag_i;
            tgt_q[waddr_i] <= wtarget_i;
        end
    end

    assign rentry_o.valid  = valid_q[raddr_i];
    assign rentry_o.tag    = tag_q[raddr_i];
    assign rentry_o.target = tgt_q[raddr_i];

endmodule

// File: rtl/branch_target_buffer.sv
// IF-stage branch target buffer with write-through bypass,
// D-stage hit/target registers and lookup/hit counters.
module branch_target_buffer
    import branch_pred_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        btb_clear,
    input  logic [31:0] pcF,
    input  logic        branchM,
    input  logic        actual_takeM,
    input  logic [31:0] pcM,
    input  logic [31:0] targetM,
    output logic        btb_hitF,
    output logic [31:0] btb_targetF,
    output logic        btb_hitD,
    output logic [31:0] btb_targetD,
    output logic [31:0] hit_cnt,
    output logic [31:0] lookup_cnt
);

    logic [BTB_DEPTH-1:0] idx_f;
    logic [BTB_DEPTH-1:0] idx_m;
    logic [TAG_W-1:0]     tag_f;
    logic [TAG_W-1:0]     tag_m;
    logic                 upd;
    btb_entry_t           rd;
    logic                 hit_f;
    logic [29:0]          tgt_f;
    logic                 unused_lsb;

    logic        hitD_q;
    logic        hitD_d;
    logic [31:0] targetD_q;
    logic [31:0] targetD_d;
    logic [31:0] hit_cnt_q;
    logic [31:0] hit_cnt_d;
    logic [31:0] lookup_cnt_q;
    logic [31:0] lookup_cnt_d;

    assign idx_f = btb_idx(pcF);
    assign tag_f = btb_tag(pcF);
    assign idx_m = btb_idx(pcM);
    assign tag_m = btb_tag(pcM);

    // A clear drops any simultaneous update, so it never bypasses.
    assign upd = branchM & actual_takeM & ~btb_clear;

    // Word-aligned PCs/targets: the low two bits carry nothing.
    assign unused_lsb = ^{pcF[1:0], pcM[1:0], targetM[1:0]};

    btb_array u_array (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (btb_clear),
        .raddr_i   (idx_f),
        .rentry_o  (rd),
        .we_i      (upd),
        .waddr_i   (idx_m),
        .wtag_i    (tag_m),
        .wtarget_i (targetM[31:2])
    );

    // Lookup with bypass; a same-index write evicts the old line.
    always_comb begin
        hit_f = 1'b0;
        tgt_f = '0;
        if (upd && (idx_m == idx_f)) begin
            hit_f = (tag_m == tag_f);
            tgt_f = targetM[31:2];
        end else begin
            hit_f = rd.valid && (rd.tag == tag_f);
            tgt_f = rd.target;
        end
    end

    assign btb_hitF    = hit_f;
    assign btb_targetF = hit_f ? {tgt_f, 2'b00} : 32'h0;

    // D-stage and counter next state: flush over stall over load.
    always_comb begin
        hitD_d       = hitD_q;
        targetD_d    = targetD_q;
        hit_cnt_d    = hit_cnt_q;
        lookup_cnt_d = lookup_cnt_q;
        if (flushD) begin
            hitD_d    = 1'b0;
            targetD_d = 32'h0;
        end else if (!stallD) begin
            hitD_d       = btb_hitF;
            targetD_d    = btb_targetF;
            lookup_cnt_d = lookup_cnt_q + 32'd1;
            if (btb_hitF) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    // D-stage registers and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitD_q       <= 1'b0;
            targetD_q    <= 32'h0;
            hit_cnt_q    <= 32'h0;
            lookup_cnt_q <= 32'h0;
        end else begin
            hitD_q       <= hitD_d;
            targetD_q    <= targetD_d;
            hit_cnt_q    <= hit_cnt_d;
            lookup_cnt_q <= lookup_cnt_d;
        end
    end

    assign btb_hitD    = hitD_q;
    assign btb_targetD = targetD_q;
    assign hit_cnt     = hit_cnt_q;
    assign lookup_cnt  = lookup_cnt_q;

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer in the IF stage, working alongside the local-history direction predictor.
- Looks up pcF every cycle and supplies a predicted target address. The hit/target pair is registered into the D stage, where the PC-select logic combines it with pred_takeD.
- Entries are written from the M stage using the resolved branch outcome.

Parameters:
- BTB_DEPTH, 6, log2 of entry count (64 entries); index = pcF[BTB_DEPTH+1:2].
- TAG_W, 30-BTB_DEPTH, tag width; tag = pc[31:BTB_DEPTH+2].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- stallD  in  1  hold D-stage output registers.
- flushD  in  1  clear D-stage output registers.
- btb_clear  in  1  synchronous invalidate of all entries.
- pcF  in  32  fetch PC for lookup.
- branchM  in  1  M-stage instruction is a conditional branch.
- actual_takeM  in  1  resolved direction of the M-stage branch.
- pcM  in  32  PC of the M-stage branch.
- targetM  in  32  resolved taken target of the M-stage branch.
- btb_hitF  out  1  combinational hit for pcF.
- btb_targetF  out  32  combinational target for pcF; 0 on miss.
- btb_hitD  out  1  registered hit, aligned with the D stage.
- btb_targetD  out  32  registered target, aligned with the D stage.
- hit_cnt  out  32  count of D-stage advances carrying a hit.
- lookup_cnt  out  32  count of D-stage advances.

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target[31:2] (30 bits). The target's low 2 bits always read as 00.
- Reset (rst=0, asynchronous):
  - All valid bits = 0.
  - btb_hitD = 0, btb_targetD = 0, hit_cnt = 0, lookup_cnt = 0.
  - Tag and target contents are don't-care.
- Lookup (combinational, zero latency in F):
  - hit = valid[idxF] & (tag[idxF] == tagF).
  - btb_targetF = {target[idxF], 2'b00} on hit, else 0.
- Write-through bypass:
  - Condition: an update is committing this cycle with the same index and tag as pcF.
  - btb_hitF and btb_targetF reflect the new value (hit=1, target=targetM) in the same cycle.
  - If the same index is written with a different tag, btb_hitF = 0 (the old entry is being evicted).
- Update at the clock edge, priority highest first:
  1. btb_clear: all valid bits = 0; any simultaneous update is dropped.
  2. branchM & actual_takeM: entry[idxM] <= {1, tagM, targetM[31:2]}. Allocates or overwrites unconditionally.
  3. branchM & ~actual_takeM: no change (entry retained; direction is handled by the PHT).
  4. Otherwise: no change.
- D-stage registers, priority highest first:
  1. flushD: btb_hitD = 0, btb_targetD = 0.
  2. stallD: hold.
  3. Otherwise: load btb_hitF / btb_targetF, bypass included.
- Counters:
  - lookup_cnt increments on each edge with ~flushD & ~stallD.
  - hit_cnt increments on the same condition when btb_hitF = 1.
  - Both wrap modulo 2^32 with no saturation. btb_clear does not reset them.
- Misaligned targetM (bits [1:0] != 0): bits [1:0] are discarded, not flagged.
- When rst deasserts mid-stream, the first edge after deassertion behaves as a normal cycle.

Decomposition:
- Shared package branch_pred_pkg holds:
  - BTB_DEPTH, TAG_W.
  - The PC index/tag slice helper functions, shared with branch_predict_local's pcF[11:2] indexing.
  - The btb_entry_t struct {valid, tag, target}.
- One sub-module, btb_array: the 2^BTB_DEPTH entry store with
  - one asynchronous read port,
  - one write port,
  - a bulk valid clear.
- The bypass, D-stage registers and counters stay in the top module.

Test Plan:
- Cold lookup: after reset, pcF=0x0040_0010 -> btb_hitF=0, btb_targetF=0; the next unstalled edge gives btb_hitD=0 and lookup_cnt=1.
- Allocate then hit: branchM=1, actual_takeM=1, pcM=0x0040_0010, targetM=0x0040_0100. On a later cycle pcF=0x0040_0010 -> btb_hitF=1, btb_targetF=0x0040_0100; one edge later btb_hitD=1 and hit_cnt increments.
- Alias eviction: entry at 0x0040_0010 is present; a taken update at pcM=0x0040_1010 (same index, different tag, targetM=0x0040_2000). pcF=0x0040_0010 afterwards -> hit=0; pcF=0x0040_1010 -> hit=1, target=0x0040_2000.
- Bypass: in the same cycle, pcF=pcM=0x0040_0020, taken update with targetM=0x0040_0300 -> btb_hitF=1, btb_targetF=0x0040_0300 in that cycle.
- Not-taken and clear:
  - A not-taken update on an existing entry leaves it hitting.
  - btb_clear=1 together with a taken update -> all lookups miss afterwards, including the updated PC.
- Stall/flush/reset:
  - With btb_hitD=1, stallD=1 for 3 cycles -> btb_hitD held and counters frozen.
  - Then flushD=1 with stallD=1 -> btb_hitD=0.
  - Asserting rst low asynchronously mid-cycle -> all outputs 0 immediately and all entries miss.
